// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver: steps the external nibble mux select and
// drives registered active-low anode/segment pins with a dead time on every digit change.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] scan_sel,
    input  logic [3:0] digit_in,
    input  logic [3:0] points,
    input  logic [3:0] blank,
    output logic [3:0] AN,
    output logic [7:0] SEGMENT
);

    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("seg7_scan_driver: SCAN_DIV must be at least 4");
    end
    if ((BLANK_CYC < 0) || (BLANK_CYC >= SCAN_DIV)) begin : g_bad_blank_cyc
        $error("seg7_scan_driver: BLANK_CYC must lie in 0..SCAN_DIV-1");
    end

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       scan_sel_r;
    logic [3:0]       an_r;
    logic [7:0]       seg_r;
    logic             tick_s;
    logic             dark_s;
    logic [3:0]       an_nxt_s;
    logic [7:0]       seg_nxt_s;

    // Slot-advance strobe and next pin values from the pre-edge scan state
    always_comb begin
        tick_s    = 1'b0;
        dark_s    = 1'b1;
        an_nxt_s  = 4'b1111;
        seg_nxt_s = 8'hFF;
        if (en) begin
            tick_s = (cnt_r == CNT_LAST);
            dark_s = (cnt_r < CNT_BLANK) || blank[scan_sel_r];
        end else begin
            tick_s = 1'b0;
            dark_s = 1'b1;
        end
        // Dead window keeps the previous digit's segments from ghosting onto the new anode
        if (!dark_s) begin
            an_nxt_s  = ~(4'b0001 << scan_sel_r);
            seg_nxt_s = {~points[scan_sel_r], seg_decode(digit_in)};
        end else begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 8'hFF;
        end
    end

    // Slot prescaler and digit index; both freeze while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            scan_sel_r <= 2'd0;
        end else if (en) begin
            if (tick_s) begin
                cnt_r      <= '0;
                scan_sel_r <= scan_sel_r + 2'd1;
            end else begin
                cnt_r      <= cnt_r + CNT_W'(1);
                scan_sel_r <= scan_sel_r;
            end
        end else begin
            cnt_r      <= cnt_r;
            scan_sel_r <= scan_sel_r;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 4'b1111;
            seg_r <= 8'hFF;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign scan_sel = scan_sel_r;
    assign AN       = an_r;
    assign SEGMENT  = seg_r;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
- Sits around the board's 4-to-1 nibble mux. It drives that mux's 2-bit select and consumes the selected 4-bit digit.
- From the selected digit it produces the registered, active-low anode and segment outputs for the board pins.
- Adds a programmable scan rate, per-digit decimal point and blanking, and an anti-ghosting dead time on every digit change.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot. Must be >= 4.
- BLANK_CYC, 2000: dead cycles at the start of each slot during which all anodes are off. Must be < SCAN_DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  scan enable. 0 = freeze and blank the display.
- scan_sel  output  2  digit index; drives the mux select. Digit 0 is the rightmost digit.
- digit_in  input  4  hex nibble returned by the mux for the current scan_sel. Combinational, valid in the same cycle.
- points  input  4  per-digit decimal point, 1 = dp lit; indexed by digit.
- blank  input  4  per-digit blank, 1 = digit forced off.
- AN  output  4  anodes, active-low, registered.
- SEGMENT  output  8  segments, active-low, registered. Bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous, active-high.
- Reset (rst=1 at a rising edge): cnt=0, scan_sel=0, AN=4'b1111, SEGMENT=8'hFF. rst has priority over en.
- Prescaler: cnt counts 0..SCAN_DIV-1 while en=1 and wraps to 0. Width is $clog2(SCAN_DIV).
  - tick = (cnt == SCAN_DIV-1) && en.
  - On tick: scan_sel <= scan_sel+1, wrapping 3 -> 0.
  - scan_sel is a register. It changes only on tick or reset.
- Output register, computed from pre-edge state each edge while en=1:
  - If cnt < BLANK_CYC, or blank[scan_sel]=1: AN <= 4'b1111 and SEGMENT <= 8'hFF.
  - Otherwise: AN <= ~(4'b0001 << scan_sel), and SEGMENT <= {~points[scan_sel], dec(digit_in)}.
  - Latency: AN/SEGMENT reflect scan_sel, cnt and digit_in from one cycle earlier.
  - Slot timing: the first visible cycle of a slot is the edge after cnt reaches BLANK_CYC. The last is the edge after cnt = SCAN_DIV-1.
- Decoder dec (7-bit {g..a}; listed below as the full 8-bit value with dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - dp on clears bit 7.
- en=0:
  - cnt and scan_sel hold.
  - AN <= 4'b1111 and SEGMENT <= 8'hFF on the next edge.
  - On re-enable, counting resumes from the held cnt. No slot is restarted.
- Simultaneous events:
  - rst with tick: reset wins.
  - tick while blank[next digit]=1: scan still advances and that slot stays dark.
  - points/blank are sampled per cycle, so changes take effect at the next edge.
- Invariant: at most one AN bit is 0 in any cycle.
- Mid-operation reset: all state returns to reset values on the same edge. There is no partial slot afterwards; scanning restarts at digit 0 with a full blank window.
- Invalid parameters (BLANK_CYC >= SCAN_DIV): elaboration-time error via generate-time check.

Test Plan:
(Bench: SCAN_DIV=8, BLANK_CYC=2; bench-side 4:1 mux model fed hexs=16'h1234, digit 0 = low nibble.)
- Reset: rst=1 for 3 cycles, en=1 -> AN=1111, SEGMENT=FF, scan_sel=0 throughout. First AN=1110 appears 3 edges after rst falls.
- Rotation: en=1, points=0, blank=0, run 40 cycles -> scan_sel steps 0,1,2,3,0 every 8 cycles.
  - Visible pairs: AN=1110/SEGMENT=99, AN=1101/B0, AN=1011/A4, AN=0111/F9.
  - Each pair is held 6 cycles after 2 dark cycles.
- DP and blank: points=4'b0101, blank=4'b1000 -> digit0 SEGMENT=19 and digit2 SEGMENT=24. The digit3 slot stays AN=1111, and scan_sel still advances 3 -> 0.
- Full decode: sweep digit_in 0..F on digit 1 -> SEGMENT matches the decoder list for all 16 values.
- Enable gating: drop en at scan_sel=2, cnt=5, for 10 cycles -> scan_sel=2 and cnt=5 held, AN=1111 from the next edge. After re-enable, AN=1011 resumes and the tick occurs 3 cycles later.
- Mid-scan reset: rst pulse at scan_sel=3, cnt=4 -> next edge scan_sel=0, AN=1111, SEGMENT=FF. Digit 0 becomes visible 3 edges after rst falls.
